// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package arm_fetch_pkg;

  localparam int FETCH_W     = 32;
  localparam int PC_INC      = 4;
  localparam int PC_READ_OFS = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction buffer between fetch and decode
// Flush beats everything; pop on empty and push on full are dropped.
module fetch_buffer
  import arm_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush && (count_q != CW'(DEPTH));
    do_pop   = pop && !flush && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and single-outstanding instruction fetch FSM
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters.
module fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pcplus8,
  input  logic             id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]    count;
  fetch_entry_t     head, push_entry;
  logic             push, pop, flush;
  logic             credit, credit_after, drop_pending;

  always_comb begin
    flush        = redirect_valid;
    pop          = (count != '0) && id_ready;
    push         = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    push_entry   = '{instr: imem_rdata, pc: addr_q};
    credit       = (int'(count) + int'(state_q == WAIT)) < DEPTH;
    credit_after = (int'(count) + 1 - int'(pop)) < DEPTH;
    // A response is still owed after this cycle; it must be swallowed in DROP.
    drop_pending = ((state_q == REQ) && imem_gnt) ||
                   (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = drop_pending ? DROP : REQ;
    end else begin
      unique case (state_q)
        IDLE: if (credit) state_d = REQ;
        REQ:  if (imem_gnt) state_d = WAIT;
        WAIT: if (imem_rvalid) state_d = credit_after ? REQ : IDLE;
        DROP: if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~WIDTH'(3);
    end else if ((state_q == REQ) && imem_gnt) begin
      pc_d   = pc_q + WIDTH'(PC_INC);
      addr_d = pc_q;
    end
  end

  always_comb begin
    imem_req   = (state_q == REQ);
    imem_addr  = pc_q;
    if_valid   = (count != '0);
    if_instr   = head.instr;
    if_pc      = head.pc;
    if_pcplus8 = head.pc + WIDTH'(PC_READ_OFS);
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic        discard;

  always_comb begin
    discard        = imem_rvalid &&
                     ((state_q == DROP) || ((state_q == WAIT) && redirect_valid));
    perf_fetched_d = push ? sat_add32(perf_fetched_q, 32'd1) : perf_fetched_q;
    perf_dropped_d = sat_add32(perf_dropped_q,
                               32'(discard) + (redirect_valid ? 32'(count) : 32'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 32-bit ARM core, directly downstream of the next-PC select mux.
- Owns the PC register and issues one word fetch at a time to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO toward decode, using a valid/ready handshake.
- A redirect (branch or exception target) from execute flushes all fetch state and restarts fetch at the new PC.

Parameters:
- WIDTH, 32: PC and instruction width in bits.
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- DEPTH, 2: instruction buffer entries, minimum 2, power of two.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  WIDTH  target PC; bits [1:0] forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  WIDTH  instruction word.
- if_valid  out  1  buffer head valid.
- if_instr  out  WIDTH  head instruction.
- if_pc  out  WIDTH  PC of head instruction.
- if_pcplus8  out  WIDTH  if_pc+8 (ARM PC-read value).
- id_ready  in  1  decode accepts head.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: imem_req=0, if_valid=0, buffer count=0, pc_q=RESET_PC, state=IDLE.
  - Instruction memory shares `reset`, so no response survives reset.
  - imem_rvalid is ignored in IDLE and REQ.
- States:
  - IDLE: no request in flight.
  - REQ: imem_req=1, imem_addr=pc_q.
  - WAIT: granted, awaiting rvalid.
  - DROP: awaiting a stale rvalid to discard.
- Credit rule: request only when count + (state==WAIT) < DEPTH, so the FIFO never overflows.
- Transitions, applied when redirect_valid=0:
  - IDLE -> REQ when credit is available.
  - REQ + gnt -> WAIT, and pc_q <= pc_q+4. Addition is modulo 2^WIDTH, so 32'hFFFF_FFFC wraps to 0.
  - REQ without gnt: hold req, and hold addr stable.
  - WAIT + rvalid: push {rdata, addr_q}, then go to REQ if credit remains after the push, else IDLE.
  - DROP + rvalid: discard, go to IDLE.
- Redirect has highest priority:
  - pc_q <= {redirect_pc[WIDTH-1:2],2'b00}, and the buffer is flushed (count=0).
  - From WAIT, or from REQ with gnt in the same cycle: go to DROP.
  - Otherwise go to REQ.
  - A response arriving in the redirect cycle itself is discarded.
  - imem_addr may change without gnt only on a redirect.
- Latency: redirect cycle N gives imem_req with the new address at N+1. With gnt at N+1 and rvalid at N+2, if_valid=1 at N+3. Throughput is one instruction per 2 cycles with single-cycle memory (one outstanding request).
- Output side:
  - if_valid = (count!=0).
  - Pop occurs when if_valid && id_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Flush overrides pop.
  - if_instr, if_pc and if_pcplus8 are stable while if_valid && !id_ready.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports perf_fetched[31:0] and perf_dropped[31:0].
  - perf_fetched increments on each push.
  - perf_dropped increments on each discarded response, plus each flushed valid entry (adds count at flush).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package arm_fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP};
  - PC_INC=4 and PC_READ_OFS=8;
  - the fetch_entry_t struct {instr, pc}.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush, count. Flush has priority; pop when empty and push when full are ignored. fetch_unit holds the FSM, PC and credits.

Test Plan:
- Reset then gnt and rvalid each 1 cycle after req, id_ready=1 -> imem_addr sequence 0,4,8; if_pc 0,4,8; if_pcplus8 8,12,16.
- id_ready=0, memory always ready -> exactly 2 pushes; imem_req stays 0 while count=2; if_instr stable; raising id_ready resumes fetch at 8.
- Redirect to 32'h100 while in WAIT; stale rvalid with 32'hDEAD arrives next cycle -> discarded, no if_valid; next imem_addr=32'h100.
- redirect_pc=32'h0000_0203 -> imem_addr=32'h200.
- pc_q=32'hFFFF_FFFC granted -> next imem_addr=32'h0.
- Redirect in the same cycle as pop and rvalid with count=1 -> count=0 next cycle; no entry from the old stream reaches decode.
